mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sits directly upstream of the I-cache and D-cache fill FSMs and in front of the single multi-cycle main memory.
- Grants the memory port to one cache at a time and muxes that cache's address and write controls onto memory.
- Routes memory data-valid pulses back only to the owning cache.
- Holds the grant until the owner drops its request and every read it issued has returned, so fill data never goes to the wrong cache.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- CNT_W, 3, outstanding-read counter width. Memory read latency must be at most 2^CNT_W - 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- icache_req  in  1  I-side request, from I-cache fill FSM fsm_busy.
- icache_addr  in  ADDR_W  I-side memory address.
- dcache_req  in  1  D-side request, from D-cache fill FSM busy or store.
- dcache_addr  in  ADDR_W  D-side memory address.
- dcache_wr  in  1  D-side write (write-through store). Valid only with dcache_req.
- dcache_wdata  in  DATA_W  D-side store data.
- mem_rdata  in  DATA_W  memory read data.
- mem_rdata_valid  in  1  memory read-data valid pulse.
- icache_grant  out  1  I side owns memory. Registered.
- dcache_grant  out  1  D side owns memory. Registered.
- icache_data_valid  out  1  mem_rdata_valid routed to I side.
- dcache_data_valid  out  1  mem_rdata_valid routed to D side.
- rdata  out  DATA_W  mem_rdata passthrough, shared by both caches.
- mem_enable  out  1  memory access strobe.
- mem_wr  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- spurious  out  1  sticky error: a return pulse arrived with zero reads outstanding.

Behaviour:
- States: IDLE, GNT_I, GNT_D. State register, last_served bit, outstanding counter and spurious flag are all cleared by async reset.
- Reset values: state=IDLE, last_served=I, outstanding=0, spurious=0. All outputs 0 in reset, except rdata, which follows mem_rdata.
- Grant outputs are decoded from the state register: icache_grant=(state==GNT_I), dcache_grant=(state==GNT_D).
- A request seen in cycle t produces its grant in cycle t+1. There is no combinational grant.
- mem_enable = (GNT_I & icache_req) | (GNT_D & dcache_req).
- mem_wr = GNT_D & dcache_req & dcache_wr. The I side never writes.
- mem_addr is the granted side's address; 0 in IDLE.
- mem_wdata = dcache_wdata whenever GNT_D; 0 otherwise.
- Issue condition: a read is issued in any cycle with mem_enable=1 and mem_wr=0.
- Outstanding counter: next = cnt + issue - (mem_rdata_valid & cnt!=0). Simultaneous issue and return leaves cnt unchanged. Saturates at 2^CNT_W - 1 and never wraps.
- If mem_rdata_valid=1 while cnt==0: spurious is set and held until reset, and no data-valid is routed.
- Data routing: icache_data_valid = mem_rdata_valid & GNT_I & cnt!=0; dcache_data_valid similarly for GNT_D. Both are combinational, zero added latency.
- IDLE transitions:
  - Only dcache_req -> GNT_D.
  - Only icache_req -> GNT_I.
  - Both requests -> grant the side opposite last_served.
  - Neither -> stay in IDLE.
  - last_served is updated on every grant.
- GNT_X hold and release:
  - Stay while X_req=1 or next outstanding != 0.
  - On release, go directly to the other side's grant if its request is high (no idle bubble); otherwise go to IDLE.
- The owner's request dropping mid-burst with reads still in flight: the grant is held, the other side waits, and the remaining returns still go to the owner.
- Write-only D access (one-cycle store): the grant is released the cycle after dcache_req drops, because no reads are outstanding.
- Async reset mid-burst: all state is cleared immediately and in-flight returns after reset are treated as spurious. The bench keeps memory idle across reset.

Test Plan:
- Lone I fill:
  - Stimulus: icache_req held 8 issue cycles, addr 0x1230..0x123E, memory latency 4.
  - Required: icache_grant 1 cycle after req; 8 icache_data_valid pulses, 0 dcache_data_valid; grant drops the cycle after cnt returns to 0.
- Simultaneous requests from reset:
  - Stimulus: both requests high in the same cycle.
  - Required: dcache_grant first (last_served=I). After D releases, GNT_I follows directly with no IDLE cycle.
- Early request drop:
  - Stimulus: I owner drops icache_req with 3 reads in flight while dcache_req is high.
  - Required: icache_grant held until the 3rd return; dcache_grant the next cycle; D sees no valid pulses meant for I.
- Store:
  - Stimulus: dcache_req=1, dcache_wr=1, addr 0x4000, wdata 0xBEEF for one cycle.
  - Required: mem_wr=1 with mem_addr 0x4000 and mem_wdata 0xBEEF; cnt stays 0; grant releases the next cycle.
- Spurious return:
  - Stimulus: mem_rdata_valid pulsed in IDLE.
  - Required: spurious=1 and sticky, no data-valid output pulses, cnt stays 0.
- Reset mid-burst:
  - Stimulus: rst_n low asynchronously during GNT_D with cnt=2.
  - Required: grants and cnt go to 0 without waiting for a clock edge; after release, the next simultaneous request is granted to D again.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Cache/memory bus bundle for mem_arbiter. The arbiter takes the slave view;
// the caches and main memory (or a bench standing in for them) take the master view.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic              icache_req;
    logic [ADDR_W-1:0] icache_addr;
    logic              dcache_req;
    logic [ADDR_W-1:0] dcache_addr;
    logic              dcache_wr;
    logic [DATA_W-1:0] dcache_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rdata_valid;
    logic              icache_grant;
    logic              dcache_grant;
    logic              icache_data_valid;
    logic              dcache_data_valid;
    logic [DATA_W-1:0] rdata;
    logic              mem_enable;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              spurious;

    modport slave (
        input  icache_req, icache_addr, dcache_req, dcache_addr, dcache_wr,
               dcache_wdata, mem_rdata, mem_rdata_valid,
        output icache_grant, dcache_grant, icache_data_valid, dcache_data_valid,
               rdata, mem_enable, mem_wr, mem_addr, mem_wdata, spurious
    );

    modport master (
        output icache_req, icache_addr, dcache_req, dcache_addr, dcache_wr,
               dcache_wdata, mem_rdata, mem_rdata_valid,
        input  icache_grant, dcache_grant, icache_data_valid, dcache_data_valid,
               rdata, mem_enable, mem_wr, mem_addr, mem_wdata, spurious
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client (I-cache / D-cache) arbiter for a single multi-cycle main memory.
// Grant is held until the owner drops its request and all of its reads have returned.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last_d;
    logic              w_last_d_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_spurious;

    logic              w_gnt_i;
    logic              w_gnt_d;
    logic              w_mem_en;
    logic              w_mem_wr;
    logic              w_issue;
    logic              w_ret;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    assign w_gnt_i  = (r_state == GNT_I);
    assign w_gnt_d  = (r_state == GNT_D);
    assign w_mem_en = (w_gnt_i & bus.icache_req) | (w_gnt_d & bus.dcache_req);
    assign w_mem_wr = w_gnt_d & bus.dcache_req & bus.dcache_wr;
    assign w_issue  = w_mem_en & ~w_mem_wr;
    // A return only counts when a read is actually outstanding.
    assign w_ret    = bus.mem_rdata_valid & (r_cnt != '0);

    assign w_mem_addr  = w_gnt_i ? bus.icache_addr :
                         w_gnt_d ? bus.dcache_addr : '0;
    assign w_mem_wdata = w_gnt_d ? bus.dcache_wdata : '0;

    // Outstanding-read counter, saturating at CNT_MAX.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_issue && !w_ret && (r_cnt != CNT_MAX)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end else if (!w_issue && w_ret) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end
    end

    // Grant FSM: round-robin on contention, direct hand-off on release.
    always_comb begin
        w_state_nxt  = r_state;
        w_last_d_nxt = r_last_d;
        case (r_state)
            IDLE: begin
                if (bus.icache_req && bus.dcache_req) begin
                    w_state_nxt = r_last_d ? GNT_I : GNT_D;
                end else if (bus.dcache_req) begin
                    w_state_nxt = GNT_D;
                end else if (bus.icache_req) begin
                    w_state_nxt = GNT_I;
                end
            end
            GNT_I: begin
                if (!bus.icache_req && (w_cnt_nxt == '0)) begin
                    w_state_nxt = bus.dcache_req ? GNT_D : IDLE;
                end
            end
            GNT_D: begin
                if (!bus.dcache_req && (w_cnt_nxt == '0)) begin
                    w_state_nxt = bus.icache_req ? GNT_I : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_state_nxt == GNT_I) begin
            w_last_d_nxt = 1'b0;
        end else if (w_state_nxt == GNT_D) begin
            w_last_d_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_last_d   <= 1'b0;
            r_cnt      <= '0;
            r_spurious <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_last_d <= w_last_d_nxt;
            r_cnt    <= w_cnt_nxt;
            if (bus.mem_rdata_valid && (r_cnt == '0)) begin
                r_spurious <= 1'b1;
            end
        end
    end

    assign bus.icache_grant      = w_gnt_i;
    assign bus.dcache_grant      = w_gnt_d;
    assign bus.icache_data_valid = w_ret & w_gnt_i;
    assign bus.dcache_data_valid = w_ret & w_gnt_d;
    assign bus.rdata             = bus.mem_rdata;
    assign bus.mem_enable        = w_mem_en;
    assign bus.mem_wr            = w_mem_wr;
    assign bus.mem_addr          = w_mem_addr;
    assign bus.mem_wdata         = w_mem_wdata;
    assign bus.spurious          = r_spurious;

endmodule
